tchk_violation_logger: RTL and testbench
========================================

// Module: tchk_violation_logger
// PURPOSE
//  Downstream consumer of a $setuphold-checked capture stage (negative setup/hold, delayed clk/data).
//  Detects each notifier toggle, counts violations and timestamps the most recent one.
//  Captures the delayed data on clk and raises an alarm once a violation threshold is reached.
//  Sits beside the checked flop; gives the bench and firmware a cycle-accurate violation record.
// PARAMETERS
//  CNT_W   8   violation counter width (saturating)
//  TS_W    16  free-running timestamp width (wraps)
//  THRESH  4   violation count that forces LOCKED; 1..2**CNT_W-1
//  HIST_D  4   history depth; used only with TCHK_HIST_EN; power of 2
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       synchronous, active-high reset
//  notifier  in   1       timing-check notifier; toggles once per violation; asynchronous to clk
//  d_d       in   1       delayed data from the checked stage
//  arm       in   1       1-cycle pulse: IDLE->ARMED
//  clr       in   1       1-cycle pulse: clear count/flag/ts; LOCKED->ARMED
//  q         out  1       d_d registered on clk
//  viol_flag out  1       sticky: >=1 violation since last clr/rst
//  viol_cnt  out  CNT_W   saturating violation count
//  last_ts   out  TS_W    ts_ctr value in the cycle the violation was detected
//  alarm     out  1       1 while in LOCKED
//  hist_idx  in   log2(HIST_D)  history read index, 0 = newest (TCHK_HIST_EN only)
//  hist_ts   out  TS_W    history entry at hist_idx, combinational read (TCHK_HIST_EN only)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE; q, viol_flag, alarm = 0; viol_cnt, last_ts, ts_ctr = 0;
//    sync flops = 0; history entries = 0.
//  Sync: notifier passes through a 2-flop synchronizer n1->n2, plus n3 <= n2.
//    viol = n2 ^ n3. Detection latency is 3 clk edges after notifier changes.
//    A notifier X counts as no change.
//    Two toggles closer than 1 clk period may merge to zero or one detected event; this is accepted.
//  ts_ctr increments every cycle and wraps 2**TS_W-1 -> 0. The sync flops and ts_ctr run in all states.
//  q <= d_d every cycle, in all states.
//  FSM:
//    IDLE:   viol ignored; arm -> ARMED.
//    ARMED:  on viol: viol_cnt <= sat(viol_cnt+1); viol_flag <= 1; last_ts <= ts_ctr;
//            when the new count == THRESH -> LOCKED.
//    LOCKED: alarm=1; viol ignored (count frozen); clr -> ARMED.
//  clr in ARMED/LOCKED: viol_cnt, viol_flag, last_ts <= 0.
//    clr+viol in the same ARMED cycle: the violation wins over the clear: cnt=1, flag=1, last_ts=ts_ctr.
//    clr+viol in LOCKED: -> ARMED with cnt=0; the violation is dropped.
//  arm outside IDLE is ignored. clr in IDLE clears the registers; state stays IDLE.
//  viol_cnt saturates at 2**CNT_W-1 and never wraps.
//  rst mid-operation returns to IDLE next edge; all state and history are lost.
// CONFIGURATION
//  TCHK_HIST_EN defined:
//    HIST_D-deep shift history of last_ts values, written on each counted violation.
//    hist_ts = entry[hist_idx].
//  TCHK_HIST_EN undefined:
//    hist_idx and hist_ts ports are absent; no history storage is built.
// STRUCTURE
//  Package tchk_pkg: typedef enum logic [1:0] {IDLE, ARMED, LOCKED} tchk_state_e;
//    default widths CNT_W_DEF, TS_W_DEF.
//  Sub-module tchk_ts_history (TS_W, HIST_D):
//    shift-register history, write-enable + data in, index read out.
//    Instantiated only under TCHK_HIST_EN.
// TESTING
//  1 rst, arm, one notifier toggle at t=25 with clk period 10
//      -> viol_flag=1 and viol_cnt=1 three edges later; last_ts = ts_ctr in the detect cycle.
//  2 four toggles spaced 50 apart, THRESH=4
//      -> viol_cnt=4, alarm=1, state LOCKED; a 5th toggle leaves viol_cnt at 4.
//  3 toggle with clr in the detect cycle (ARMED) -> viol_cnt=1, viol_flag=1.
//    repeat in LOCKED -> viol_cnt=0, state ARMED, alarm=0.
//  4 CNT_W=2, THRESH=3: toggles in IDLE are ignored (cnt stays 0); after arm, reaches 3 -> LOCKED.
//    TS_W=4: last_ts follows the wrap 15->0 correctly.
//  5 rst asserted mid-ARMED with cnt=2 -> next edge all outputs 0, state IDLE; arm required again.
//  6 TCHK_HIST_EN: three violations at ts 5, 20, 40 -> hist_ts[0]=40, [1]=20, [2]=5, [3]=0.

Source files
------------

// File: rtl/tchk_pkg.sv
// Shared types and default widths for the timing-check violation logger.
// The optional history feature is enabled by defining TCHK_HIST_EN.
package tchk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED
    } tchk_state_e;

    localparam int CNT_W_DEF = 8;
    localparam int TS_W_DEF  = 16;

endpackage

// File: rtl/tchk_violation_logger_if.sv
// Signal bundle between the checked capture stage and the violation logger.
// The master side drives notifier/data/control; the slave side returns the record.
interface tchk_violation_logger_if
    import tchk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF
);

    logic             notifier;
    logic             d_d;
    logic             arm;
    logic             clr;
    logic             q;
    logic             viol_flag;
    logic [CNT_W-1:0] viol_cnt;
    logic [TS_W-1:0]  last_ts;
    logic             alarm;

    modport master (
        output notifier, d_d, arm, clr,
        input  q, viol_flag, viol_cnt, last_ts, alarm
    );

    modport slave (
        input  notifier, d_d, arm, clr,
        output q, viol_flag, viol_cnt, last_ts, alarm
    );

endinterface

// File: rtl/tchk_ts_history.sv
// Shift-register history of violation timestamps; entry 0 is the newest.
// Only instantiated when TCHK_HIST_EN is defined.
module tchk_ts_history #(
    parameter int TS_W   = 16,
    parameter int HIST_D = 4,
    localparam int IDX_W = (HIST_D > 1) ? $clog2(HIST_D) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [TS_W-1:0]  wr_ts,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TS_W-1:0]  rd_ts
);

    logic [TS_W-1:0] mem [HIST_D];

    // Push the new timestamp in at the head, older entries move down.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HIST_D; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[0] <= wr_ts;
            for (int i = 1; i < HIST_D; i++) mem[i] <= mem[i-1];
        end
    end

    assign rd_ts = mem[rd_idx];

endmodule

// File: rtl/tchk_violation_logger.sv
// Counts and timestamps notifier toggles from a timing-checked flop, with lockout alarm.
// Define TCHK_HIST_EN to add a timestamp history with an indexed read port.
module tchk_violation_logger
    import tchk_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int THRESH = 4
`ifdef TCHK_HIST_EN
    ,
    parameter int HIST_D = 4
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    tchk_violation_logger_if.slave    bus
`ifdef TCHK_HIST_EN
    ,
    input  logic [$clog2(HIST_D)-1:0] hist_idx,
    output logic [TS_W-1:0]           hist_ts
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    tchk_state_e      state;
    tchk_state_e      state_n;
    logic             n1;
    logic             n2;
    logic             n3;
    logic             viol;
    logic [TS_W-1:0]  ts_ctr;
    logic [TS_W-1:0]  last_ts;
    logic [TS_W-1:0]  ts_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_inc;
    logic             flag;
    logic             flag_n;
    logic             q;

    // Synchronize the notifier; an unknown level holds the previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            n1 <= 1'b0;
            n2 <= 1'b0;
            n3 <= 1'b0;
        end else begin
            n1 <= (bus.notifier !== 1'b0 && bus.notifier !== 1'b1) ? n1 : bus.notifier;
            n2 <= n1;
            n3 <= n2;
        end
    end

    assign viol = n2 ^ n3;

    // Free-running timestamp and data capture, active in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_ctr <= '0;
            q      <= 1'b0;
        end else begin
            ts_ctr <= ts_ctr + 1'b1;
            q      <= bus.d_d;
        end
    end

    // A same-cycle clear zeroes the base so a coincident violation lands as count 1.
    assign cnt_base = bus.clr ? '0 : cnt;
    assign cnt_inc  = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;

    // State and record registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            flag    <= 1'b0;
            last_ts <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            flag    <= flag_n;
            last_ts <= ts_n;
        end
    end

    // Next-state and record update.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        flag_n  = flag;
        ts_n    = last_ts;
        if (bus.clr) begin
            cnt_n  = '0;
            flag_n = 1'b0;
            ts_n   = '0;
        end
        unique case (state)
            IDLE: begin
                if (bus.arm) state_n = ARMED;
            end
            ARMED: begin
                if (viol) begin
                    cnt_n  = cnt_inc;
                    flag_n = 1'b1;
                    ts_n   = ts_ctr;
                    if (cnt_inc == THR) state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (bus.clr) state_n = ARMED;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.q         = q;
    assign bus.viol_flag = flag;
    assign bus.viol_cnt  = cnt;
    assign bus.last_ts   = last_ts;
    assign bus.alarm     = (state == LOCKED);

`ifdef TCHK_HIST_EN
    logic hist_we;

    assign hist_we = (state == ARMED) && viol;

    tchk_ts_history #(
        .TS_W   (TS_W),
        .HIST_D (HIST_D)
    ) u_hist (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (hist_we),
        .wr_ts  (ts_ctr),
        .rd_idx (hist_idx),
        .rd_ts  (hist_ts)
    );
`endif

endmodule

// File: tb/tb_tchk_violation_logger.sv
// Directed bench for tchk_violation_logger: a default instance and a narrow one.
// History checks are compiled in when TCHK_HIST_EN is defined.
module tb_tchk_violation_logger;
    import tchk_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [15:0] ts_m;
    logic [3:0]  ts_m2;

    tchk_violation_logger_if #(.CNT_W(8), .TS_W(16)) bus_a ();
    tchk_violation_logger_if #(.CNT_W(2), .TS_W(4))  bus_b ();

`ifdef TCHK_HIST_EN
    logic [1:0]  hist_idx;
    logic [15:0] hist_ts;
`endif

    tchk_violation_logger #(
        .CNT_W  (8),
        .TS_W   (16),
        .THRESH (4)
`ifdef TCHK_HIST_EN
        ,
        .HIST_D (4)
`endif
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_a.slave)
`ifdef TCHK_HIST_EN
        ,
        .hist_idx (hist_idx),
        .hist_ts  (hist_ts)
`endif
    );

    tchk_violation_logger #(
        .CNT_W  (2),
        .TS_W   (4),
        .THRESH (3)
`ifdef TCHK_HIST_EN
        ,
        .HIST_D (4)
`endif
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_b.slave)
`ifdef TCHK_HIST_EN
        ,
        .hist_idx (2'd0),
        .hist_ts  ()
`endif
    );

    // Rising edges at 10, 20, 30, ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Reference timestamp counters.
    always @(posedge clk) begin
        if (rst) begin
            ts_m  <= '0;
            ts_m2 <= '0;
        end else begin
            ts_m  <= ts_m + 16'd1;
            ts_m2 <= ts_m2 + 4'd1;
        end
    end

    // Toggle notifier mid-cycle, return one tick after the counting edge.
    task automatic detect(input bit sm, input bit with_clr, output logic [15:0] ets);
        @(negedge clk);
        if (sm) bus_b.notifier = ~bus_b.notifier;
        else    bus_a.notifier = ~bus_a.notifier;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ets = sm ? 16'(ts_m2) : ts_m;
        if (with_clr) begin
            if (sm) bus_b.clr = 1'b1;
            else    bus_a.clr = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_a.clr = 1'b0;
        bus_b.clr = 1'b0;
    endtask

    task automatic wait_ts(input bit sm, input logic [15:0] v);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = sm ? (16'(ts_m2) == v) : (ts_m == v);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_ts timeout target %0d", v);
        end
    endtask

    task automatic pulse_arm(input bit sm);
        @(negedge clk);
        if (sm) bus_b.arm = 1'b1;
        else    bus_a.arm = 1'b1;
        @(posedge clk);
        #1;
        bus_a.arm = 1'b0;
        bus_b.arm = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus_a.d_d = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.q !== 1'b0) begin
            errors++; $display("FAIL reset_q got %0b exp 0", bus_a.q);
        end
        checks++;
        if (bus_a.viol_flag !== 1'b0) begin
            errors++; $display("FAIL reset_flag got %0b exp 0", bus_a.viol_flag);
        end
        checks++;
        if (bus_a.viol_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_cnt got %0d exp 0", bus_a.viol_cnt);
        end
        checks++;
        if (bus_a.last_ts !== 16'd0) begin
            errors++; $display("FAIL reset_ts got %0d exp 0", bus_a.last_ts);
        end
        checks++;
        if (bus_a.alarm !== 1'b0) begin
            errors++; $display("FAIL reset_alarm got %0b exp 0", bus_a.alarm);
        end
        rst = 1'b0;
        bus_a.d_d = 1'b0;
    endtask

    task automatic test_idle_ignore();
        logic [15:0] e;
        detect(1'b0, 1'b0, e);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_a.viol_cnt !== 8'd0 || bus_a.viol_flag !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore cnt %0d flag %0b exp 0 0", bus_a.viol_cnt, bus_a.viol_flag);
        end
    endtask

    task automatic test_single();
        logic [15:0] e;
        pulse_arm(1'b0);
        @(negedge clk);
        bus_a.notifier = ~bus_a.notifier;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        e = ts_m;
        checks++;
        if (bus_a.viol_cnt !== 8'd0) begin
            errors++; $display("FAIL single_early got %0d exp 0", bus_a.viol_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.viol_cnt !== 8'd1 || bus_a.viol_flag !== 1'b1) begin
            errors++;
            $display("FAIL single_cnt cnt %0d flag %0b exp 1 1", bus_a.viol_cnt, bus_a.viol_flag);
        end
        checks++;
        if (bus_a.last_ts !== e) begin
            errors++; $display("FAIL single_ts got %0d exp %0d", bus_a.last_ts, e);
        end
    endtask

    task automatic test_q();
        @(negedge clk);
        bus_a.d_d = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.q !== 1'b1) begin
            errors++; $display("FAIL q_high got %0b exp 1", bus_a.q);
        end
        @(negedge clk);
        bus_a.d_d = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.q !== 1'b0) begin
            errors++; $display("FAIL q_low got %0b exp 0", bus_a.q);
        end
    endtask

    task automatic test_clr_armed();
        logic [15:0] e;
        detect(1'b0, 1'b1, e);
        checks++;
        if (bus_a.viol_cnt !== 8'd1 || bus_a.viol_flag !== 1'b1 || bus_a.last_ts !== e) begin
            errors++;
            $display("FAIL clr_armed cnt %0d flag %0b ts %0d exp 1 1 %0d",
                     bus_a.viol_cnt, bus_a.viol_flag, bus_a.last_ts, e);
        end
    endtask

    task automatic test_lock();
        logic [15:0] e;
        logic [15:0] keep;
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(posedge clk);
            detect(1'b0, 1'b0, e);
        end
        keep = e;
        checks++;
        if (bus_a.viol_cnt !== 8'd4 || bus_a.alarm !== 1'b1) begin
            errors++;
            $display("FAIL lock cnt %0d alarm %0b exp 4 1", bus_a.viol_cnt, bus_a.alarm);
        end
        repeat (2) @(posedge clk);
        detect(1'b0, 1'b0, e);
        checks++;
        if (bus_a.viol_cnt !== 8'd4 || bus_a.last_ts !== keep) begin
            errors++;
            $display("FAIL lock_frozen cnt %0d ts %0d exp 4 %0d", bus_a.viol_cnt, bus_a.last_ts, keep);
        end
    endtask

    task automatic test_clr_locked();
        logic [15:0] e;
        detect(1'b0, 1'b1, e);
        checks++;
        if (bus_a.viol_cnt !== 8'd0 || bus_a.alarm !== 1'b0 ||
            bus_a.viol_flag !== 1'b0 || bus_a.last_ts !== 16'd0) begin
            errors++;
            $display("FAIL clr_locked cnt %0d alarm %0b flag %0b ts %0d exp 0 0 0 0",
                     bus_a.viol_cnt, bus_a.alarm, bus_a.viol_flag, bus_a.last_ts);
        end
        detect(1'b0, 1'b0, e);
        checks++;
        if (bus_a.viol_cnt !== 8'd1 || bus_a.last_ts !== e) begin
            errors++;
            $display("FAIL rearmed cnt %0d ts %0d exp 1 %0d", bus_a.viol_cnt, bus_a.last_ts, e);
        end
    endtask

    task automatic test_rst_mid();
        logic [15:0] e;
        detect(1'b0, 1'b0, e);
        checks++;
        if (bus_a.viol_cnt !== 8'd2) begin
            errors++; $display("FAIL pre_rst cnt %0d exp 2", bus_a.viol_cnt);
        end
        do_reset();
        checks++;
        if (bus_a.viol_cnt !== 8'd0 || bus_a.viol_flag !== 1'b0 ||
            bus_a.last_ts !== 16'd0 || bus_a.alarm !== 1'b0 || bus_a.q !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid cnt %0d flag %0b ts %0d alarm %0b q %0b exp all 0",
                     bus_a.viol_cnt, bus_a.viol_flag, bus_a.last_ts, bus_a.alarm, bus_a.q);
        end
        detect(1'b0, 1'b0, e);
        checks++;
        if (bus_a.viol_cnt !== 8'd0) begin
            errors++; $display("FAIL rst_needs_arm cnt %0d exp 0", bus_a.viol_cnt);
        end
        pulse_arm(1'b0);
        detect(1'b0, 1'b0, e);
        checks++;
        if (bus_a.viol_cnt !== 8'd1) begin
            errors++; $display("FAIL rst_rearm cnt %0d exp 1", bus_a.viol_cnt);
        end
    endtask

    task automatic test_small();
        logic [15:0] e;
        detect(1'b1, 1'b0, e);
        checks++;
        if (bus_b.viol_cnt !== 2'd0) begin
            errors++; $display("FAIL small_idle cnt %0d exp 0", bus_b.viol_cnt);
        end
        pulse_arm(1'b1);
        wait_ts(1'b1, 16'd13);
        detect(1'b1, 1'b0, e);
        checks++;
        if (bus_b.last_ts !== 4'd15 || bus_b.viol_cnt !== 2'd1) begin
            errors++;
            $display("FAIL small_ts15 ts %0d cnt %0d exp 15 1", bus_b.last_ts, bus_b.viol_cnt);
        end
        wait_ts(1'b1, 16'd14);
        detect(1'b1, 1'b0, e);
        checks++;
        if (bus_b.last_ts !== 4'd0 || bus_b.viol_cnt !== 2'd2) begin
            errors++;
            $display("FAIL small_wrap ts %0d cnt %0d exp 0 2", bus_b.last_ts, bus_b.viol_cnt);
        end
        detect(1'b1, 1'b0, e);
        checks++;
        if (bus_b.viol_cnt !== 2'd3 || bus_b.alarm !== 1'b1 || bus_b.last_ts !== e[3:0]) begin
            errors++;
            $display("FAIL small_lock cnt %0d alarm %0b ts %0d exp 3 1 %0d",
                     bus_b.viol_cnt, bus_b.alarm, bus_b.last_ts, e[3:0]);
        end
    endtask

`ifdef TCHK_HIST_EN
    task automatic test_hist();
        logic [15:0] e;
        logic [15:0] exp_h [4];
        exp_h[0] = 16'd40;
        exp_h[1] = 16'd20;
        exp_h[2] = 16'd5;
        exp_h[3] = 16'd0;
        do_reset();
        pulse_arm(1'b0);
        wait_ts(1'b0, 16'd3);
        detect(1'b0, 1'b0, e);
        wait_ts(1'b0, 16'd18);
        detect(1'b0, 1'b0, e);
        wait_ts(1'b0, 16'd38);
        detect(1'b0, 1'b0, e);
        for (int i = 0; i < 4; i++) begin
            hist_idx = 2'(i);
            #1;
            checks++;
            if (hist_ts !== exp_h[i]) begin
                errors++;
                $display("FAIL hist[%0d] got %0d exp %0d", i, hist_ts, exp_h[i]);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.notifier = 1'b0;
        bus_a.d_d = 1'b0;
        bus_a.arm = 1'b0;
        bus_a.clr = 1'b0;
        bus_b.notifier = 1'b0;
        bus_b.d_d = 1'b0;
        bus_b.arm = 1'b0;
        bus_b.clr = 1'b0;
`ifdef TCHK_HIST_EN
        hist_idx = 2'd0;
`endif
        test_reset();
        test_idle_ignore();
        test_single();
        test_q();
        test_clr_armed();
        test_lock();
        test_clr_locked();
        test_rst_mid();
        test_small();
`ifdef TCHK_HIST_EN
        test_hist();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
